// File: rtl/oddp_rx.sv
`default_nettype none
// ============================================================================
// Module   : oddp_rx
// Purpose  : Odd-parity serial frame receiver. Frame is start(0), DATA_W data
//            bits MSB first, parity, stop(1), sampled on bit_en. Recovers the
//            word and flags parity/framing errors.
// Option   : ODDP_RX_ERRCNT_EN builds an 8-bit saturating error counter;
//            without it err_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module oddp_rx #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bad_q, par_bad_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;

  // Next-state and output decode; nothing moves unless bit_en samples the line.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    data_out_d   = data_out_q;
    valid_d      = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    if (bit_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_in) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          // First bit received migrates up to the MSB.
          shift_d = {shift_q[DATA_W-2:0], rx_in};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_PAR;
          end
        end
        ST_PAR: begin
          // Odd parity: data plus parity bit must hold an odd count of ones.
          par_bad_d = ~((^shift_q) ^ rx_in);
          state_d   = ST_STOP;
        end
        ST_STOP: begin
          data_out_d   = shift_q;
          valid_d      = 1'b1;
          parity_err_d = par_bad_q;
          frame_err_d  = ~rx_in;
          state_d      = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      data_out_q   <= data_out_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef ODDP_RX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Count errored frames once each, saturating at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (valid_d && (parity_err_d || frame_err_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

  assign data_out   = data_out_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_oddp_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_oddp_rx
// Purpose  : Self-checking bench for oddp_rx. Frames are driven serially;
//            their expected results queue up and are compared whenever the
//            receiver pulses valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oddp_rx;

  localparam int DATA_W = 4;

  logic              clk;
  logic              rst_n;
  logic              bit_en;
  logic              rx_in;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [7:0]        err_cnt;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              perr;
    logic              ferr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_err_cnt = 0;
  logic prev_valid = 1'b0;

  oddp_rx #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one bit for one strobe, then hold bit_en low for gap cycles.
  task automatic send_bit(input logic b, input int gap);
    @(negedge clk);
    rx_in  = b;
    bit_en = 1'b1;
    repeat (gap) begin
      @(negedge clk);
      bit_en = 1'b0;
    end
  endtask

  // Full frame; expected result is queued when the frame is driven.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic bad_par,
                            input logic stop, input int gap, input logic chk_busy);
    logic p;
    exp_t e;
    p      = ~(^d) ^ bad_par;
    e.data = d;
    e.perr = bad_par;
    e.ferr = ~stop;
    exp_q.push_back(e);
    send_bit(1'b0, gap);
    if (chk_busy) begin
      @(negedge clk);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      rx_in = d[DATA_W-1];
      bit_en = 1'b1;
      repeat (gap) begin
        @(negedge clk);
        bit_en = 1'b0;
      end
      for (int i = DATA_W - 2; i >= 0; i--) send_bit(d[i], gap);
    end else begin
      for (int i = DATA_W - 1; i >= 0; i--) send_bit(d[i], gap);
    end
    send_bit(p, gap);
    send_bit(stop, gap);
  endtask

  // Scoreboard: compare each valid pulse with the oldest queued frame.
  always @(negedge clk) begin
    if (valid) begin
      chk("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data_out",   {28'd0, data_out},   {28'd0, e.data});
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        chk("frame_err",  {31'd0, frame_err},  {31'd0, e.ferr});
        chk("busy_at_valid", {31'd0, busy}, 32'd0);
`ifdef ODDP_RX_ERRCNT_EN
        if ((e.perr || e.ferr) && exp_err_cnt < 255) exp_err_cnt++;
`endif
        chk("err_cnt", {24'd0, err_cnt}, exp_err_cnt);
      end
    end else if (rst_n && (parity_err || frame_err)) begin
      chk("flags_idle", {30'd0, parity_err, frame_err}, 32'd0);
    end
    prev_valid <= valid;
  end

  initial begin
    rst_n  = 1'b0;
    bit_en = 1'b0;
    rx_in  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_out", {28'd0, data_out}, 32'd0);
    chk("rst_valid",    {31'd0, valid},    32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_err_cnt",  {24'd0, err_cnt},  32'd0);
    rst_n = 1'b1;

    // Clean frame 0,1011,0,1 -> 4'hB.
    send_frame(4'hB, 1'b0, 1'b1, 0, 1'b1);
    // Parity error 0,1011,1,1.
    send_frame(4'hB, 1'b1, 1'b1, 0, 1'b0);
    // Framing error then back-to-back clean 4'hF.
    send_frame(4'h0, 1'b0, 1'b0, 0, 1'b0);
    send_frame(4'hF, 1'b0, 1'b1, 0, 1'b0);
    // Varied words, mixed errors.
    send_frame(4'h6, 1'b0, 1'b1, 0, 1'b0);
    send_frame(4'h9, 1'b1, 1'b0, 1, 1'b0);
    // Gapped strobe, every third cycle.
    send_frame(4'hB, 1'b0, 1'b1, 2, 1'b1);
    @(negedge clk);
    bit_en = 1'b0;
    repeat (6) @(negedge clk);
    chk("data_out_hold", {28'd0, data_out}, 32'd11);
    chk("queue_drained_1", exp_q.size(), 32'd0);

    // Reset after three bits aborts the frame.
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    @(negedge clk);
    bit_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    chk("midrst_busy",     {31'd0, busy},     32'd0);
    chk("midrst_data_out", {28'd0, data_out}, 32'd0);
    chk("midrst_valid",    {31'd0, valid},    32'd0);
    exp_err_cnt = 0;
    chk("midrst_err_cnt",  {24'd0, err_cnt},  32'd0);
    rst_n = 1'b1;
    send_frame(4'hB, 1'b0, 1'b1, 0, 1'b0);
    send_frame(4'h3, 1'b0, 1'b1, 1, 1'b0);

    // Saturation: 260 parity-error frames.
    for (int n = 0; n < 260; n++) send_frame(4'(n), 1'b1, 1'b1, 0, 1'b0);
    @(negedge clk);
    bit_en = 1'b0;
    repeat (4) @(negedge clk);
`ifdef ODDP_RX_ERRCNT_EN
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
`else
    chk("err_cnt_off", {24'd0, err_cnt}, 32'd0);
`endif
    chk("queue_drained_2", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
